// File: rtl/tx_len_pattern_gen.sv
// Command-driven bulk transmit generator: takes a 5-byte command (mode, 32-bit length)
// and streams that many pattern bytes on an NB-byte AXI-stream with exact tkeep/tlast.
module tx_len_pattern_gen #(
    parameter int         OUT_EW    = 2,
    parameter logic [7:0] LFSR_SEED = 8'h01,
    localparam int        NB        = 1 << OUT_EW
) (
    input  logic            clk,
    input  logic            rst,
    output logic            i_tready,
    input  logic            i_tvalid,
    input  logic [7:0]      i_tdata,
    input  logic            o_tready,
    output logic            o_tvalid,
    output logic [8*NB-1:0] o_tdata,
    output logic [NB-1:0]   o_tkeep,
    output logic            o_tlast,
    output logic            busy,
    output logic            done
);

    typedef enum logic {S_CMD, S_SEND} state_t;

    localparam logic [31:0] NB32 = 32'(NB);

    state_t          r_state;
    logic [2:0]      r_byte_cnt;
    logic [1:0]      r_mode;
    logic [23:0]     r_len;
    logic [31:0]     r_idx;
    logic [31:0]     r_rem;
    logic [7:0]      r_lfsr;
    logic            r_tvalid;
    logic [8*NB-1:0] r_tdata;
    logic [NB-1:0]   r_tkeep;
    logic            r_tlast;
    logic            r_busy;
    logic            r_done;

    logic            w_accept;
    logic            w_load;
    logic [31:0]     w_new_len;
    logic [31:0]     w_gen_idx;
    logic [31:0]     w_gen_rem;
    logic [7:0]      w_gen_lfsr;
    logic [31:0]     w_lane_idx;
    logic [7:0]      w_lane_byte;
    logic [7:0]      w_s;
    logic [8*NB-1:0] w_beat_data;
    logic [NB-1:0]   w_beat_keep;
    logic            w_beat_last;
    logic [31:0]     w_nxt_idx;
    logic [31:0]     w_nxt_rem;
    logic [7:0]      w_nxt_lfsr;

    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    assign i_tready  = (r_state == S_CMD) & ~rst;
    assign w_accept  = i_tvalid & i_tready;
    assign w_load    = w_accept & (r_byte_cnt == 3'd4);
    assign w_new_len = {i_tdata, r_len};

    // The generator state registers always describe the beat *after* the one on the bus;
    // a fresh command substitutes index 0, the seed and the new length instead.
    assign w_gen_idx  = w_load ? 32'd0     : r_idx;
    assign w_gen_rem  = w_load ? w_new_len : r_rem;
    assign w_gen_lfsr = w_load ? LFSR_SEED : r_lfsr;

    always_comb begin
        w_s         = w_gen_lfsr;
        w_lane_idx  = '0;
        w_lane_byte = '0;
        w_beat_data = '0;
        w_beat_keep = '0;
        for (int j = 0; j < NB; j++) begin
            w_lane_idx = w_gen_idx + 32'(j);
            case (r_mode)
                2'd1:    w_lane_byte = 8'hFF;
                2'd2:    w_lane_byte = w_s;
                default: w_lane_byte = w_lane_idx[7:0];
            endcase
            if (32'(j) < w_gen_rem) begin
                w_beat_keep[j]        = 1'b1;
                w_beat_data[8*j +: 8] = w_lane_byte;
            end
            w_s = lfsr_step(w_s);
        end
        w_nxt_lfsr  = w_s;
        w_nxt_idx   = w_gen_idx + NB32;
        w_beat_last = (w_gen_rem <= NB32);
        w_nxt_rem   = w_beat_last ? 32'd0 : (w_gen_rem - NB32);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_CMD;
            r_byte_cnt <= '0;
            r_mode     <= '0;
            r_len      <= '0;
            r_idx      <= '0;
            r_rem      <= '0;
            r_lfsr     <= LFSR_SEED;
            r_tvalid   <= 1'b0;
            r_tdata    <= '0;
            r_tkeep    <= '0;
            r_tlast    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_CMD: begin
                    if (w_accept) begin
                        case (r_byte_cnt)
                            3'd0:    r_mode         <= i_tdata[1:0];
                            3'd1:    r_len[7:0]     <= i_tdata;
                            3'd2:    r_len[15:8]    <= i_tdata;
                            3'd3:    r_len[23:16]   <= i_tdata;
                            default: ;
                        endcase
                        if (r_byte_cnt == 3'd4) begin
                            r_byte_cnt <= '0;
                            if (w_new_len == 32'd0) begin
                                r_done <= 1'b1;
                            end else begin
                                r_state  <= S_SEND;
                                r_busy   <= 1'b1;
                                r_tvalid <= 1'b1;
                                r_tdata  <= w_beat_data;
                                r_tkeep  <= w_beat_keep;
                                r_tlast  <= w_beat_last;
                                r_idx    <= w_nxt_idx;
                                r_rem    <= w_nxt_rem;
                                r_lfsr   <= w_nxt_lfsr;
                            end
                        end else begin
                            r_byte_cnt <= r_byte_cnt + 3'd1;
                        end
                    end
                end
                S_SEND: begin
                    if (o_tready) begin
                        if (r_tlast) begin
                            r_state  <= S_CMD;
                            r_busy   <= 1'b0;
                            r_done   <= 1'b1;
                            r_tvalid <= 1'b0;
                            r_tdata  <= '0;
                            r_tkeep  <= '0;
                            r_tlast  <= 1'b0;
                        end else begin
                            r_tdata <= w_beat_data;
                            r_tkeep <= w_beat_keep;
                            r_tlast <= w_beat_last;
                            r_idx   <= w_nxt_idx;
                            r_rem   <= w_nxt_rem;
                            r_lfsr  <= w_nxt_lfsr;
                        end
                    end
                end
                default: r_state <= S_CMD;
            endcase
        end
    end

    assign o_tvalid = r_tvalid;
    assign o_tdata  = r_tdata;
    assign o_tkeep  = r_tkeep;
    assign o_tlast  = r_tlast;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule
